// File: rtl/match_referee.sv
// Match referee: collects one committed action per player, strobes actionEnable for
// EN_CYCLES, lets health settle, then judges the round and decides when the match ends.
module match_referee #(
   parameter int unsigned EN_CYCLES     = 2,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned MAX_ROUNDS    = 30,
   parameter int unsigned ROUND_W       = 5
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               commit1,
   input  logic [2:0]         action1_sw,
   input  logic               commit2,
   input  logic [2:0]         action2_sw,
   input  logic [1:0]         health1,
   input  logic [1:0]         health2,
   output logic [2:0]         action1,
   output logic [2:0]         action2,
   output logic               actionEnable,
   output logic               isGameOver,
   output logic [1:0]         winner,
   output logic [ROUND_W-1:0] round_count
);

   localparam logic [2:0] StIdle    = 3'd0;
   localparam logic [2:0] StCollect = 3'd1;
   localparam logic [2:0] StIssue   = 3'd2;
   localparam logic [2:0] StSettle  = 3'd3;
   localparam logic [2:0] StJudge   = 3'd4;
   localparam logic [2:0] StOver    = 3'd5;

   localparam logic [2:0] ActAwait = 3'b010;

   localparam logic [1:0] WinNone = 2'b00;
   localparam logic [1:0] WinP1   = 2'b01;
   localparam logic [1:0] WinP2   = 2'b10;
   localparam logic [1:0] WinDraw = 2'b11;

   localparam logic [15:0]        EnLast     = 16'(EN_CYCLES - 1);
   localparam logic [15:0]        SettleLast = 16'(SETTLE_CYCLES - 1);
   localparam logic [ROUND_W-1:0] RoundMax   = ROUND_W'(MAX_ROUNDS);

   logic [2:0]         state_q, state_d;
   logic [15:0]        cnt_q, cnt_d;
   logic               flag1_q, flag1_d;
   logic               flag2_q, flag2_d;
   logic [2:0]         act1_q, act1_d;
   logic [2:0]         act2_q, act2_d;
   logic [ROUND_W-1:0] round_q, round_d;
   logic [1:0]         winner_q, winner_d;
   logic               dead1, dead2;

   assign dead1 = (health1 == 2'b00);
   assign dead2 = (health2 == 2'b00);

   // Next-state logic for the round sequencer.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      flag1_d  = flag1_q;
      flag2_d  = flag2_q;
      act1_d   = act1_q;
      act2_d   = act2_q;
      round_d  = round_q;
      winner_d = winner_q;
      case (state_q)
         StIdle: begin
            if (start) state_d = StCollect;
         end
         StCollect: begin
            // First commit per player wins; later ones are ignored until the next round.
            if (commit1 && !flag1_q) begin
               act1_d  = action1_sw;
               flag1_d = 1'b1;
            end
            if (commit2 && !flag2_q) begin
               act2_d  = action2_sw;
               flag2_d = 1'b1;
            end
            if (flag1_d && flag2_d) begin
               state_d = StIssue;
               cnt_d   = '0;
            end
         end
         StIssue: begin
            if (cnt_q == EnLast) begin
               state_d = StSettle;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StSettle: begin
            if (cnt_q == SettleLast) begin
               state_d = StJudge;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StJudge: begin
            round_d = (round_q == RoundMax) ? round_q : round_q + 1'b1;
            flag1_d = 1'b0;
            flag2_d = 1'b0;
            act1_d  = ActAwait;
            act2_d  = ActAwait;
            state_d = StOver;
            if (dead1 && dead2) begin
               winner_d = WinDraw;
            end else if (dead1) begin
               winner_d = WinP2;
            end else if (dead2) begin
               winner_d = WinP1;
            end else if (round_d == RoundMax) begin
               if (health1 > health2)      winner_d = WinP1;
               else if (health2 > health1) winner_d = WinP2;
               else                        winner_d = WinDraw;
            end else begin
               state_d = StCollect;
            end
         end
         StOver: begin
            // Terminal: only reset leaves.
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         flag1_q  <= 1'b0;
         flag2_q  <= 1'b0;
         act1_q   <= ActAwait;
         act2_q   <= ActAwait;
         round_q  <= '0;
         winner_q <= WinNone;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         flag1_q  <= flag1_d;
         flag2_q  <= flag2_d;
         act1_q   <= act1_d;
         act2_q   <= act2_d;
         round_q  <= round_d;
         winner_q <= winner_d;
      end
   end

   // Strobe and game-over are decoded from state so reset drops them immediately.
   assign actionEnable = (state_q == StIssue);
   assign isGameOver   = (state_q == StOver);
   assign winner       = winner_q;
   assign round_count  = round_q;
   assign action1      = act1_q;
   assign action2      = act2_q;

endmodule

// File: tb/tb_match_referee.sv
// Bench for match_referee: table-driven round sequence plus hand-written corner cases.
module tb_match_referee;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       commit1, commit2;
   logic [2:0] action1_sw, action2_sw;
   logic [1:0] health1, health2;

   logic [2:0] action1, action2;
   logic       actionEnable, isGameOver;
   logic [1:0] winner;
   logic [4:0] round_count;

   logic [2:0] action1_3, action2_3;
   logic       actionEnable_3, isGameOver_3;
   logic [1:0] winner_3;
   logic [1:0] round_count_3;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   match_referee dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .commit1      (commit1),
      .action1_sw   (action1_sw),
      .commit2      (commit2),
      .action2_sw   (action2_sw),
      .health1      (health1),
      .health2      (health2),
      .action1      (action1),
      .action2      (action2),
      .actionEnable (actionEnable),
      .isGameOver   (isGameOver),
      .winner       (winner),
      .round_count  (round_count)
   );

   match_referee #(
      .EN_CYCLES     (1),
      .SETTLE_CYCLES (2),
      .MAX_ROUNDS    (3),
      .ROUND_W       (2)
   ) dut3 (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .commit1      (commit1),
      .action1_sw   (action1_sw),
      .commit2      (commit2),
      .action2_sw   (action2_sw),
      .health1      (health1),
      .health2      (health2),
      .action1      (action1_3),
      .action2      (action2_3),
      .actionEnable (actionEnable_3),
      .isGameOver   (isGameOver_3),
      .winner       (winner_3),
      .round_count  (round_count_3)
   );

   typedef struct {
      logic       st;
      logic       c1;
      logic [2:0] a1;
      logic       c2;
      logic [2:0] a2;
      logic [1:0] h1;
      logic [1:0] h2;
      logic       ae;
      logic [2:0] e1;
      logic [2:0] e2;
      logic       go;
      logic [1:0] win;
      logic [4:0] rc;
   } vec_t;

   vec_t tbl[20];

   function automatic vec_t mk(int st, int c1, int a1, int c2, int a2, int h1, int h2,
                               int ae, int e1, int e2, int go, int win, int rc);
      vec_t v;
      v.st = 1'(st);  v.c1 = 1'(c1); v.a1 = 3'(a1); v.c2 = 1'(c2); v.a2 = 3'(a2);
      v.h1 = 2'(h1);  v.h2 = 2'(h2); v.ae = 1'(ae); v.e1 = 3'(e1); v.e2 = 3'(e2);
      v.go = 1'(go);  v.win = 2'(win); v.rc = 5'(rc);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      start = 1'b0; commit1 = 1'b0; commit2 = 1'b0;
      action1_sw = 3'd0; action2_sw = 3'd0;
   endtask

   task automatic reset_pulse();
      reset = 1'b0;
      step();
      reset = 1'b1;
   endtask

   initial begin
      // Row i: inputs applied during cycle i, outputs expected during cycle i.
      tbl[0]  = mk(0,1,5,0,0,3,3, 0,2,2,0,0,0); // commit in IDLE ignored
      tbl[1]  = mk(1,0,0,0,0,3,3, 0,2,2,0,0,0);
      tbl[2]  = mk(0,0,0,0,0,3,3, 0,2,2,0,0,0);
      tbl[3]  = mk(0,1,1,0,0,3,3, 0,2,2,0,0,0);
      tbl[4]  = mk(0,0,0,0,0,3,3, 0,1,2,0,0,0);
      tbl[5]  = mk(0,1,7,0,0,3,3, 0,1,2,0,0,0); // second commit1 ignored
      tbl[6]  = mk(0,0,0,1,3,3,3, 0,1,2,0,0,0);
      tbl[7]  = mk(0,1,0,1,4,3,3, 1,1,3,0,0,0); // commits during ISSUE dropped
      tbl[8]  = mk(0,0,0,0,0,3,3, 1,1,3,0,0,0);
      tbl[9]  = mk(0,0,0,0,0,3,3, 0,1,3,0,0,0);
      tbl[10] = mk(0,0,0,0,0,3,3, 0,1,3,0,0,0); // JUDGE
      tbl[11] = mk(0,0,0,0,0,3,3, 0,2,2,0,0,1);
      tbl[12] = mk(0,1,0,1,6,3,3, 0,2,2,0,0,1); // simultaneous commits
      tbl[13] = mk(0,1,7,0,0,3,3, 1,0,6,0,0,1);
      tbl[14] = mk(0,0,0,0,0,3,3, 1,0,6,0,0,1);
      tbl[15] = mk(0,0,0,0,0,2,0, 0,0,6,0,0,1);
      tbl[16] = mk(0,0,0,0,0,2,0, 0,0,6,0,0,1); // JUDGE, player 2 dead
      tbl[17] = mk(1,1,5,1,5,2,0, 0,2,2,1,1,2);
      tbl[18] = mk(1,1,5,1,5,2,0, 0,2,2,1,1,2);
      tbl[19] = mk(0,0,0,0,0,3,3, 0,2,2,1,1,2);

      reset = 1'b0;
      idle_inputs();
      health1 = 2'd3; health2 = 2'd3;
      step();
      step();
      chk("rst ae", 32'(actionEnable), 32'd0);
      chk("rst go", 32'(isGameOver), 32'd0);
      chk("rst win", 32'(winner), 32'd0);
      chk("rst rc", 32'(round_count), 32'd0);
      chk("rst a1", 32'(action1), 32'd2);
      chk("rst a2", 32'(action2), 32'd2);
      reset = 1'b1;

      for (int i = 0; i < 20; i++) begin
         start = tbl[i].st; commit1 = tbl[i].c1; action1_sw = tbl[i].a1;
         commit2 = tbl[i].c2; action2_sw = tbl[i].a2;
         health1 = tbl[i].h1; health2 = tbl[i].h2;
         chk($sformatf("row%0d ae", i), 32'(actionEnable), 32'(tbl[i].ae));
         chk($sformatf("row%0d a1", i), 32'(action1), 32'(tbl[i].e1));
         chk($sformatf("row%0d a2", i), 32'(action2), 32'(tbl[i].e2));
         chk($sformatf("row%0d go", i), 32'(isGameOver), 32'(tbl[i].go));
         chk($sformatf("row%0d win", i), 32'(winner), 32'(tbl[i].win));
         chk($sformatf("row%0d rc", i), 32'(round_count), 32'(tbl[i].rc));
         step();
      end
      idle_inputs();

      // Both players dead in the same round: draw.
      health1 = 2'd3; health2 = 2'd3;
      reset_pulse();
      start = 1'b1; step(); start = 1'b0;
      commit1 = 1'b1; action1_sw = 3'd4; commit2 = 1'b1; action2_sw = 3'd5;
      step();
      idle_inputs();
      chk("draw ae c1", 32'(actionEnable), 32'd1);
      chk("draw a1", 32'(action1), 32'd4);
      step();
      chk("draw ae c2", 32'(actionEnable), 32'd1);
      step();
      chk("draw ae settle", 32'(actionEnable), 32'd0);
      health1 = 2'd0; health2 = 2'd0;
      step();
      chk("draw go judge", 32'(isGameOver), 32'd0);
      step();
      chk("draw go", 32'(isGameOver), 32'd1);
      chk("draw win", 32'(winner), 32'd3);
      chk("draw rc", 32'(round_count), 32'd1);

      // Reset while actionEnable is high aborts at once; IDLE ignores commits.
      health1 = 2'd3; health2 = 2'd3;
      reset_pulse();
      start = 1'b1; step(); start = 1'b0;
      commit1 = 1'b1; action1_sw = 3'd1; commit2 = 1'b1; action2_sw = 3'd1;
      step();
      idle_inputs();
      chk("abort ae before", 32'(actionEnable), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort ae", 32'(actionEnable), 32'd0);
      chk("abort a1", 32'(action1), 32'd2);
      chk("abort rc", 32'(round_count), 32'd0);
      step();
      reset = 1'b1;
      commit1 = 1'b1; action1_sw = 3'd6; commit2 = 1'b1; action2_sw = 3'd7;
      step();
      step();
      idle_inputs();
      chk("idle ae", 32'(actionEnable), 32'd0);
      chk("idle a1", 32'(action1), 32'd2);
      chk("idle a2", 32'(action2), 32'd2);

      // Round limit on the MAX_ROUNDS=3 instance: health 3 vs 1 -> player 1 wins.
      health1 = 2'd3; health2 = 2'd1;
      reset_pulse();
      start = 1'b1; step(); start = 1'b0;
      for (int r = 1; r <= 3; r++) begin
         commit1 = 1'b1; action1_sw = 3'(r); commit2 = 1'b1; action2_sw = 3'd0;
         step();
         idle_inputs();
         chk($sformatf("lim r%0d ae on", r), 32'(actionEnable_3), 32'd1);
         chk($sformatf("lim r%0d a1", r), 32'(action1_3), 32'(r));
         step();
         chk($sformatf("lim r%0d ae off", r), 32'(actionEnable_3), 32'd0);
         step();
         step();
         chk($sformatf("lim r%0d go judge", r), 32'(isGameOver_3), 32'd0);
         step();
         chk($sformatf("lim r%0d rc", r), 32'(round_count_3), 32'(r));
         chk($sformatf("lim r%0d go", r), 32'(isGameOver_3), (r == 3) ? 32'd1 : 32'd0);
         chk($sformatf("lim r%0d win", r), 32'(winner_3), (r == 3) ? 32'd1 : 32'd0);
      end
      start = 1'b1; commit1 = 1'b1; commit2 = 1'b1;
      step();
      step();
      idle_inputs();
      chk("lim over ae", 32'(actionEnable_3), 32'd0);
      chk("lim over go", 32'(isGameOver_3), 32'd1);
      chk("lim over rc", 32'(round_count_3), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/match_referee.md
Name: match_referee

Overview:
- Central sequencer between the player input switches and the two player-state modules.
- Latches each player's committed action and issues a single `actionEnable` strobe per round.
- After each round it reads both players' health, counts rounds and decides `isGameOver` and the winner.
- Upstream of the player modules for `action1`, `action2` and `actionEnable`; downstream of them for `health1` and `health2`.

Parameters:
- EN_CYCLES, 2, number of cycles `actionEnable` is held high per round (≥1).
- SETTLE_CYCLES, 1, cycles `actionEnable` is held low before health is judged (≥1).
- MAX_ROUNDS, 30, round limit; reaching it ends the match.
- ROUND_W, 5, width of `round_count`; must hold MAX_ROUNDS.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a match from IDLE.
- commit1  in  1  one-cycle pulse; player 1 commits `action1_sw`.
- action1_sw  in  3  player 1 action encoding: kick 000, punch 001, await 010, jump 011, left1 100, left2 101, right1 110, right2 111.
- commit2  in  1  one-cycle pulse; player 2 commits `action2_sw`.
- action2_sw  in  3  player 2 action, same encoding.
- health1  in  2  player 1 health from its player module.
- health2  in  2  player 2 health from its player module.
- action1  out  3  latched player 1 action driven to both player modules.
- action2  out  3  latched player 2 action.
- actionEnable  out  1  round strobe.
- isGameOver  out  1  match finished.
- winner  out  2  00 none, 01 player1, 10 player2, 11 draw.
- round_count  out  ROUND_W  rounds completed.

Behaviour:
- Reset (async, `reset`==0):
  - state=IDLE, `actionEnable`=0, `isGameOver`=0, `winner`=00, `round_count`=0.
  - `action1`=`action2`=010 (await); both committed flags cleared; all internal counters 0.
  - Reset mid-round aborts the round immediately; no partial strobe survives.
- FSM states: IDLE, COLLECT, ISSUE, SETTLE, JUDGE, OVER. All transitions are registered.
- IDLE:
  - `start`=1 → COLLECT next cycle.
  - Commits are ignored.
- COLLECT:
  - `commitN`=1 with flagN clear: latch `actionN_sw` into `actionN` and set flagN.
  - `commitN` with flagN already set is ignored; the first commit wins.
  - Simultaneous `commit1` and `commit2` are both accepted in the same cycle.
  - In the first cycle both flags are set (including the cycle they become set), go to ISSUE. `actionEnable` rises in the first ISSUE cycle, i.e. 1 cycle after the second commit.
- ISSUE:
  - `actionEnable`=1 for exactly EN_CYCLES cycles, then → SETTLE.
  - `action1`/`action2` are held stable throughout.
- SETTLE:
  - `actionEnable`=0 for SETTLE_CYCLES cycles, then → JUDGE.
  - Actions remain stable.
- JUDGE (one cycle):
  - `round_count` += 1, saturating at MAX_ROUNDS.
  - Both flags cleared; `action1`/`action2` reset to 010.
  - Evaluate on the sampled `health1`/`health2`:
    - both == 0 → `winner`=11;
    - only `health1` == 0 → `winner`=10;
    - only `health2` == 0 → `winner`=01;
    - neither dead and updated `round_count`==MAX_ROUNDS → higher health wins, equal → 11.
  - Any of these cases → OVER with `isGameOver`=1 next cycle; otherwise → COLLECT.
- OVER:
  - `isGameOver`=1 and `winner`/`round_count` held.
  - `start` and commits are ignored.
  - Only reset leaves OVER.
- `winner` is 00 whenever `isGameOver`=0.
- `actionEnable` is never high outside ISSUE and always drops between rounds, so the player modules re-arm.
- Commits arriving during ISSUE, SETTLE or JUDGE are dropped; they are not queued.

Test Plan:
- Reset, `start`, `commit1` with 001 at cycle 3, `commit2` with 011 at cycle 6 → `actionEnable` high cycles 7–8, low 9; JUDGE at cycle 10; `round_count`=1; `action1`/`action2` show 001/011 during cycles 7–9 and 010 from cycle 11.
- Simultaneous `commit1`=000 and `commit2`=110 in COLLECT, then a second `commit1`=111 → `action1` stays 000; `actionEnable` 1 cycle after the commits.
- Hold `health2`=00 and `health1`=10 at JUDGE → `isGameOver`=1, `winner`=01; further `start`/commits cause no `actionEnable`.
- Both health 00 at JUDGE → `winner`=11. Run MAX_ROUNDS=3 with health 11 vs 01 → after round 3, `winner`=01 and `round_count`=3.
- Assert reset during ISSUE with `actionEnable`=1 → `actionEnable`=0 and state IDLE immediately; no commit accepted until `start`.
